alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter IO_BUS_WIDTH, default 32, is the operand and data-path width.
REQ-002 Parameter CTRL_BUS_WIDTH, default 6, is the ALU control code width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: i_clk, i_rst_n.
REQ-004 Ports, as name / direction / width / meaning:
- i_clk / in / 1 / clock, rising edge
- i_rst_n / in / 1 / asynchronous active-low reset
- i_valid / in / 1 / upstream instruction valid
- o_ready / out / 1 / block can accept an instruction
- i_opcode / in / 6 / instruction bits [31:26]
- i_funct / in / 6 / instruction bits [5:0]
- i_shamt / in / 5 / instruction bits [10:6]
- i_imm / in / 16 / instruction bits [15:0]
- i_rs_data / in / IO_BUS_WIDTH / rs register value
- i_rt_data / in / IO_BUS_WIDTH / rt register value
- i_flush / in / 1 / synchronous discard of all held entries
- o_valid / out / 1 / output entry valid
- i_ready / in / 1 / downstream ALU stage accepts the entry
- o_alu_ctrl / out / CTRL_BUS_WIDTH / ALU operation code
- o_data_A / out / IO_BUS_WIDTH / ALU operand A
- o_data_B / out / IO_BUS_WIDTH / ALU operand B
- o_illegal / out / 1 / unsupported opcode or funct

Function
REQ-005 A transfer SHALL occur on an input when i_valid and o_ready are both high at a rising edge, and on the output when o_valid and i_ready are both high.
REQ-006 Storage SHALL be a 2-entry skid buffer: a main output register plus one skid register.
REQ-007 o_ready SHALL be registered and high exactly when the skid register is empty.
REQ-008 Latency SHALL be 1 cycle from an accepted input to o_valid, provided the main register is empty or being drained.
REQ-009 Order SHALL be preserved, with no loss and no duplication.
REQ-010 When the main register drains while the skid register is full, the skid entry SHALL move to the main register in the same cycle.
REQ-011 Simultaneous input transfer and output transfer with the skid register empty SHALL replace the main entry, leaving occupancy unchanged.
REQ-012 Decoding SHALL be combinational on the inputs and registered at capture.
- R-type (opcode 000000): o_alu_ctrl = i_funct for the funct values 000000, 000010, 000011, 000100, 000110, 000111, 100000-100111, 101010.
REQ-013 For R-type SLL/SRL/SRA (funct 000000/000010/000011), A SHALL be the zero-extended i_shamt and B SHALL be rt.
REQ-014 For R-type SLLV/SRLV/SRAV, A SHALL be rt and B SHALL be rs.
REQ-015 For all other R-type operations, A SHALL be rs and B SHALL be rt.
REQ-016 I-type opcodes SHALL map, with A = rs throughout:
- 001000 ADDI -> 100000, B = sign-extended imm
- 001001 ADDIU -> 100001, B = sign-extended imm
- 001010 SLTI -> 101010, B = sign-extended imm
- 001100 ANDI -> 100100, B = zero-extended imm
- 001101 ORI -> 100101, B = zero-extended imm
- 001110 XORI -> 100110, B = zero-extended imm
- 100011 LW and 101011 SW -> 100000, B = sign-extended imm
REQ-017 Opcode 001111 (LUI) SHALL map to 001001 (pass B), with B = {imm, zeros}.
REQ-018 Any other opcode, or an unlisted R-type funct, SHALL produce o_illegal = 1, o_alu_ctrl = 001001, A = 0 and B = 0, and SHALL still be transferred normally.
REQ-019 i_flush SHALL clear both entries at the next edge, and an input offered in that cycle SHALL be dropped.
REQ-020 After a flush, o_valid SHALL be 0 and o_ready SHALL be 1 in the following cycle.
REQ-021 i_flush SHALL take priority over all transfers.
REQ-022 Data outputs SHALL hold their last value while o_valid = 0, and SHALL hold stable while o_valid = 1 and i_ready = 0.

Reset
REQ-023 While i_rst_n = 0, regardless of clock, the outputs SHALL be: o_valid = 0, o_ready = 0, o_alu_ctrl = 0, o_data_A = 0, o_data_B = 0, o_illegal = 0, and both entries empty.
REQ-024 o_ready SHALL rise at the first rising edge after reset deassertion.
REQ-025 Reset asserted mid-transfer SHALL discard all held entries.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- ADDI, rs = 0x00000005, imm = 0xFFFF, i_ready = 1 -> after 1 cycle: ctrl = 100000, A = 0x00000005, B = 0xFFFFFFFF.
- SLL, shamt = 4, rt = 0x00000001 -> ctrl = 000000, A = 0x00000004, B = 0x00000001; SRAV, rs = 3, rt = 0x80000000 -> ctrl = 000111, A = 0x80000000, B = 0x00000003.
- LUI, imm = 0x1234 -> ctrl = 001001, B = 0x12340000. Opcode 111111 -> o_illegal = 1, A = B = 0.
- i_ready = 0 with three back-to-back valid inputs -> two accepted, o_ready = 0 on the third; then i_ready = 1 -> all three delivered in order on consecutive cycles.
- Skid buffer full, i_flush = 1 together with i_valid = 1 -> next cycle o_valid = 0, o_ready = 1, and the offered input is never delivered.
- i_rst_n pulsed low mid-stream with o_valid = 1 -> all outputs are 0 immediately (asynchronously); o_ready = 1 after the first edge; the pre-reset entries are never delivered.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per cycle into ALU control and
// operands, then holds it in a 2-entry skid buffer (main + skid register).
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_valid / o_ready      upstream handshake
//   i_opcode .. i_rt_data  instruction fields and register operands
//   i_flush                synchronous discard of held entries
//   o_valid / i_ready      downstream handshake
//   o_alu_ctrl, o_data_A,
//   o_data_B, o_illegal    registered decode result of the main entry
module alu_issue_stage #(
    parameter int IO_BUS_WIDTH   = 32,
    parameter int CTRL_BUS_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [5:0]                i_opcode,
    input  logic [5:0]                i_funct,
    input  logic [4:0]                i_shamt,
    input  logic [15:0]               i_imm,
    input  logic [IO_BUS_WIDTH-1:0]   i_rs_data,
    input  logic [IO_BUS_WIDTH-1:0]   i_rt_data,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CTRL_BUS_WIDTH-1:0] o_alu_ctrl,
    output logic [IO_BUS_WIDTH-1:0]   o_data_A,
    output logic [IO_BUS_WIDTH-1:0]   o_data_B,
    output logic                      o_illegal
);

    localparam int W = IO_BUS_WIDTH;
    localparam int C = CTRL_BUS_WIDTH;

    typedef struct packed {
        logic         illegal;
        logic [C-1:0] ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } entry_t;

    entry_t dec;
    entry_t m_q, m_n;
    entry_t s_q, s_n;
    logic   m_valid, m_valid_n;
    logic   s_valid, s_valid_n;
    logic   rdy_q;
    logic   in_fire, out_fire;

    logic [W-1:0] imm_sx;
    logic [W-1:0] imm_zx;
    logic [W-1:0] imm_hi;

    assign imm_sx = {{(W-16){i_imm[15]}}, i_imm};
    assign imm_zx = {{(W-16){1'b0}}, i_imm};
    assign imm_hi = {i_imm, {(W-16){1'b0}}};

    // Unsupported encodings still travel down the pipe, flagged,
    // as a pass-B of zero so the ALU result is harmless.
    always_comb begin
        dec         = '0;
        dec.illegal = 1'b1;
        dec.ctrl    = C'(6'b001001);
        case (i_opcode)
            6'b000000: begin
                case (i_funct)
                    6'b000000, 6'b000010, 6'b000011: begin
                        dec.illegal = 1'b0;
                        dec.ctrl    = C'(i_funct);
                        dec.a       = W'(i_shamt);
                        dec.b       = i_rt_data;
                    end
                    6'b000100, 6'b000110, 6'b000111: begin
                        dec.illegal = 1'b0;
                        dec.ctrl    = C'(i_funct);
                        dec.a       = i_rt_data;
                        dec.b       = i_rs_data;
                    end
                    6'b100000, 6'b100001, 6'b100010,
                    6'b100011, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010: begin
                        dec.illegal = 1'b0;
                        dec.ctrl    = C'(i_funct);
                        dec.a       = i_rs_data;
                        dec.b       = i_rt_data;
                    end
                    default: ;
                endcase
            end
            6'b001000, 6'b100011, 6'b101011: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b100000);
                dec.a       = i_rs_data;
                dec.b       = imm_sx;
            end
            6'b001001: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b100001);
                dec.a       = i_rs_data;
                dec.b       = imm_sx;
            end
            6'b001010: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b101010);
                dec.a       = i_rs_data;
                dec.b       = imm_sx;
            end
            6'b001100: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b100100);
                dec.a       = i_rs_data;
                dec.b       = imm_zx;
            end
            6'b001101: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b100101);
                dec.a       = i_rs_data;
                dec.b       = imm_zx;
            end
            6'b001110: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b100110);
                dec.a       = i_rs_data;
                dec.b       = imm_zx;
            end
            6'b001111: begin
                dec.illegal = 1'b0;
                dec.ctrl    = C'(6'b001001);
                dec.a       = i_rs_data;
                dec.b       = imm_hi;
            end
            default: ;
        endcase
    end

    assign in_fire  = i_valid & rdy_q;
    assign out_fire = m_valid & i_ready;

    always_comb begin
        m_n       = m_q;
        s_n       = s_q;
        m_valid_n = m_valid;
        s_valid_n = s_valid;
        if (i_flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (!m_valid || out_fire) begin
            // Main is free this cycle: oldest entry (skid) goes first.
            if (s_valid) begin
                m_valid_n = 1'b1;
                m_n       = s_q;
                s_valid_n = in_fire;
                if (in_fire) s_n = dec;
            end else begin
                m_valid_n = in_fire;
                if (in_fire) m_n = dec;
            end
        end else if (in_fire) begin
            s_valid_n = 1'b1;
            s_n       = dec;
        end
    end

    // Data fields only change on a load, so they hold while idle/stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_q     <= '0;
            s_q     <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            m_q     <= m_n;
            s_q     <= s_n;
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            rdy_q   <= !s_valid_n;
        end
    end

    assign o_ready    = rdy_q;
    assign o_valid    = m_valid;
    assign o_alu_ctrl = m_q.ctrl;
    assign o_data_A   = m_q.a;
    assign o_data_B   = m_q.b;
    assign o_illegal  = m_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode vectors, skid-buffer
// backpressure, flush and asynchronous reset behaviour.
module tb_alu_issue_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_opcode;
    logic [5:0]  i_funct;
    logic [4:0]  i_shamt;
    logic [15:0] i_imm;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_alu_ctrl;
    logic [31:0] o_data_A;
    logic [31:0] o_data_B;
    logic        o_illegal;

    int vectors;
    int miscompares;

    alu_issue_stage #(
        .IO_BUS_WIDTH(32),
        .CTRL_BUS_WIDTH(6)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_opcode(i_opcode),
        .i_funct(i_funct),
        .i_shamt(i_shamt),
        .i_imm(i_imm),
        .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_alu_ctrl(o_alu_ctrl),
        .o_data_A(o_data_A),
        .o_data_B(o_data_B),
        .o_illegal(o_illegal)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        i_valid   = 1'b1;
        i_opcode  = op;
        i_funct   = fn;
        i_shamt   = sh;
        i_imm     = imm;
        i_rs_data = rs;
        i_rt_data = rt;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_flush = 1'b0;
        drive(6'b001000, 6'd0, 5'd0, 16'h0001, 32'h7, 32'h0);
        #1;
        vectors++;
        if ({o_valid, o_ready, o_illegal} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b%b%b want 000", o_valid, o_ready, o_illegal);
        end
        vectors++;
        if ({o_alu_ctrl, o_data_A, o_data_B} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h %h %h want 0", o_alu_ctrl, o_data_A, o_data_B);
        end
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_pre_edge got %b want 0", o_ready);
        end
        tick();
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_first_edge got rdy=%b vld=%b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_addi();
        i_ready = 1'b1;
        drive(6'b001000, 6'd0, 5'd0, 16'hFFFF, 32'h5, 32'h0);
        tick();
        i_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_alu_ctrl !== 6'b100000 ||
            o_data_A !== 32'h5 || o_data_B !== 32'hFFFFFFFF || o_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL addi got v=%b c=%b A=%h B=%h il=%b want 1 100000 5 ffffffff 0",
                     o_valid, o_alu_ctrl, o_data_A, o_data_B, o_illegal);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_data_B !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL addi_idle_hold got v=%b B=%h want 0 ffffffff", o_valid, o_data_B);
        end
    endtask

    task automatic test_shift();
        i_ready = 1'b1;
        drive(6'b000000, 6'b000000, 5'd4, 16'h0, 32'h0, 32'h1);
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_alu_ctrl !== 6'b000000 ||
            o_data_A !== 32'h4 || o_data_B !== 32'h1) begin
            miscompares++;
            $display("FAIL sll got v=%b c=%b A=%h B=%h want 1 000000 4 1",
                     o_valid, o_alu_ctrl, o_data_A, o_data_B);
        end
        drive(6'b000000, 6'b000111, 5'd9, 16'h0, 32'h3, 32'h80000000);
        tick();
        i_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_alu_ctrl !== 6'b000111 ||
            o_data_A !== 32'h80000000 || o_data_B !== 32'h3) begin
            miscompares++;
            $display("FAIL srav got v=%b c=%b A=%h B=%h want 1 000111 80000000 3",
                     o_valid, o_alu_ctrl, o_data_A, o_data_B);
        end
        tick();
    endtask

    task automatic test_imm_illegal();
        i_ready = 1'b1;
        drive(6'b001111, 6'd0, 5'd0, 16'h1234, 32'h0, 32'h0);
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_alu_ctrl !== 6'b001001 ||
            o_data_B !== 32'h12340000 || o_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL lui got v=%b c=%b B=%h il=%b want 1 001001 12340000 0",
                     o_valid, o_alu_ctrl, o_data_B, o_illegal);
        end
        drive(6'b001100, 6'd0, 5'd0, 16'h8001, 32'hA5, 32'h0);
        tick();
        vectors++;
        if (o_alu_ctrl !== 6'b100100 || o_data_A !== 32'hA5 || o_data_B !== 32'h00008001) begin
            miscompares++;
            $display("FAIL andi got c=%b A=%h B=%h want 100100 a5 00008001",
                     o_alu_ctrl, o_data_A, o_data_B);
        end
        drive(6'b111111, 6'd0, 5'd3, 16'hBEEF, 32'h11, 32'h22);
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_alu_ctrl !== 6'b001001 ||
            o_data_A !== 32'h0 || o_data_B !== 32'h0) begin
            miscompares++;
            $display("FAIL illegal_op got v=%b il=%b c=%b A=%h B=%h want 1 1 001001 0 0",
                     o_valid, o_illegal, o_alu_ctrl, o_data_A, o_data_B);
        end
        drive(6'b000000, 6'b000001, 5'd3, 16'h0, 32'h11, 32'h22);
        tick();
        i_valid = 1'b0;
        vectors++;
        if (o_illegal !== 1'b1 || o_alu_ctrl !== 6'b001001 || o_data_A !== 32'h0) begin
            miscompares++;
            $display("FAIL illegal_funct got il=%b c=%b A=%h want 1 001001 0",
                     o_illegal, o_alu_ctrl, o_data_A);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h1, 32'h0);
        tick();
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h2, 32'h0);
        tick();
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h3, 32'h0);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full_ready got %b want 0", o_ready);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_data_A !== 32'h1 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stall got v=%b A=%h rdy=%b want 1 1 0", o_valid, o_data_A, o_ready);
        end
        i_ready = 1'b1;
        #1;
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_data_A !== 32'h2) begin
            miscompares++;
            $display("FAIL b2b_second got v=%b A=%h want 1 2", o_valid, o_data_A);
        end
        tick();
        i_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b1 || o_data_A !== 32'h3) begin
            miscompares++;
            $display("FAIL b2b_third got v=%b A=%h want 1 3", o_valid, o_data_A);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_drained got v=%b rdy=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h41, 32'h0);
        tick();
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h42, 32'h0);
        tick();
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h43, 32'h0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state got v=%b rdy=%b want 0 1", o_valid, o_ready);
        end
        vectors++;
        if (o_data_A !== 32'h41) begin
            miscompares++;
            $display("FAIL flush_hold got A=%h want 41", o_data_A);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_leak cycle %0d got v=%b A=%h want 0", k, o_valid, o_data_A);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h51, 32'h0);
        tick();
        drive(6'b001000, 6'd0, 5'd0, 16'h0, 32'h52, 32'h0);
        #2;
        vectors++;
        if (o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre got v=%b want 1", o_valid);
        end
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_valid, o_ready, o_illegal} !== 3'b000 ||
            {o_alu_ctrl, o_data_A, o_data_B} !== 70'd0) begin
            miscompares++;
            $display("FAIL rst_mid_async got v=%b r=%b c=%h A=%h B=%h want all 0",
                     o_valid, o_ready, o_alu_ctrl, o_data_A, o_data_B);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ready got rdy=%b v=%b want 1 0", o_ready, o_valid);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_leak cycle %0d got v=%b want 0", k, o_valid);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_addi();
        test_shift();
        test_imm_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
